// File: rtl/dma_rq_tag_manager.sv
// Read-request generator and tag tracker for the DMA host-to-card path.
// Splits one command into MRRS-bounded, boundary-aligned reads and tracks tag occupancy until completion.
module dma_rq_tag_manager #(
    parameter int C_WINDOW_SIZE           = 16,
    parameter int C_LOG2_MAX_READ_REQUEST = 9
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic [63:0]                   CMD_ADDR,
    input  logic [31:0]                   CMD_LEN,
    output logic                          REQ_VALID,
    input  logic                          REQ_READY,
    output logic [63:0]                   REQ_ADDR,
    output logic [10:0]                   REQ_DWORDS,
    output logic [7:0]                    REQ_TAG,
    output logic [C_WINDOW_SIZE-1:0]      BUSY_TAGS,
    output logic [C_WINDOW_SIZE*11-1:0]   SIZE_TAGS,
    input  logic [C_WINDOW_SIZE-1:0]      COMPLETED_TAGS,
    output logic [63:0]                   CURRENT_WINDOW_SIZE,
    output logic [63:0]                   WORD_COUNT,
    output logic                          BUSY,
    output logic                          DONE
);
    localparam int          W    = C_WINDOW_SIZE;
    localparam int          N    = C_LOG2_MAX_READ_REQUEST;
    localparam logic [31:0] MRRS = 32'(1) << N;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, next_state;

    logic [63:0]  addr_r;
    logic [31:0]  remain_r;
    logic [63:0]  cmd_addr_al;
    logic [31:0]  cmd_len_al;
    logic [63:0]  src_addr;
    logic [31:0]  src_remain;
    logic [31:0]  space;
    logic [31:0]  chunk;
    logic         accept;
    logic         hs;
    logic         load;
    logic         drain_done;
    logic [W-1:0] set_mask;
    logic [W-1:0] eff_busy;
    logic [W-1:0] busy_next;
    logic [7:0]   free_idx;
    logic         free_found;
    logic [63:0]  busy_count;

    assign cmd_addr_al = CMD_ADDR & ~64'h3;
    assign cmd_len_al  = CMD_LEN & ~32'h3;
    assign accept      = CMD_VALID && CMD_READY;
    assign hs          = REQ_VALID && REQ_READY;

    // The first chunk is cut straight from the command so REQ_VALID rises the cycle after accept.
    assign src_addr   = (state == IDLE) ? cmd_addr_al : addr_r;
    assign src_remain = (state == IDLE) ? cmd_len_al : remain_r;
    assign space      = MRRS - 32'(src_addr[N-1:0]);
    assign chunk      = (src_remain < space) ? src_remain : space;

    always_comb begin
        set_mask   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        busy_count = '0;
        for (int j = 0; j < W; j++) begin
            if (hs && REQ_TAG == 8'(j)) set_mask[j] = 1'b1;
        end
        // The tag handshaking this cycle is not yet in BUSY_TAGS but must not be handed out again.
        eff_busy = BUSY_TAGS | set_mask;
        for (int j = W - 1; j >= 0; j--) begin
            if (!eff_busy[j]) begin
                free_found = 1'b1;
                free_idx   = 8'(j);
            end
        end
        busy_next = (BUSY_TAGS & ~COMPLETED_TAGS) | set_mask;
        for (int j = 0; j < W; j++) begin
            busy_count = busy_count + 64'(busy_next[j]);
        end
    end

    assign load = free_found &&
                  ((accept && cmd_len_al != 32'd0) ||
                   (state == ISSUE && remain_r != 32'd0 && (!REQ_VALID || hs)));
    assign drain_done = (state == DRAIN) && (BUSY_TAGS == '0) && !REQ_VALID;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && cmd_len_al != 32'd0) next_state = ISSUE;
            ISSUE:   if (remain_r == 32'd0 && hs)       next_state = DRAIN;
            DRAIN:   if (drain_done)                    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CMD_READY           <= 1'b1;
            REQ_VALID           <= 1'b0;
            REQ_ADDR            <= '0;
            REQ_DWORDS          <= '0;
            REQ_TAG             <= '0;
            BUSY_TAGS           <= '0;
            SIZE_TAGS           <= '0;
            CURRENT_WINDOW_SIZE <= '0;
            WORD_COUNT          <= '0;
            BUSY                <= 1'b0;
            DONE                <= 1'b0;
            addr_r              <= '0;
            remain_r            <= '0;
        end else begin
            CMD_READY           <= (next_state == IDLE);
            DONE                <= 1'b0;
            BUSY_TAGS           <= busy_next;
            CURRENT_WINDOW_SIZE <= busy_count;
            if (load) begin
                REQ_VALID  <= 1'b1;
                REQ_ADDR   <= src_addr;
                REQ_DWORDS <= 11'(chunk >> 2);
                REQ_TAG    <= free_idx;
                addr_r     <= src_addr + 64'(chunk);
                remain_r   <= src_remain - chunk;
            end else if (hs) begin
                REQ_VALID <= 1'b0;
            end
            if (hs) WORD_COUNT <= WORD_COUNT + 64'(REQ_DWORDS);
            for (int j = 0; j < W; j++) begin
                if (set_mask[j]) SIZE_TAGS[11*j +: 11] <= REQ_DWORDS;
            end
            if (accept) begin
                WORD_COUNT <= '0;
                if (cmd_len_al == 32'd0) DONE <= 1'b1;
                else                     BUSY <= 1'b1;
            end
            if (drain_done) begin
                DONE <= 1'b1;
                BUSY <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dma_rq_tag_manager.sv
// Self-checking bench for dma_rq_tag_manager: a request/tag model checked every cycle
// plus directed scenarios with hand-computed values.
module tb_dma_rq_tag_manager;
    localparam int W    = 16;
    localparam int N    = 9;
    localparam int MRRS = 512;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              CMD_VALID = 1'b0;
    logic              CMD_READY;
    logic [63:0]       CMD_ADDR = '0;
    logic [31:0]       CMD_LEN = '0;
    logic              REQ_VALID;
    logic              REQ_READY = 1'b0;
    logic [63:0]       REQ_ADDR;
    logic [10:0]       REQ_DWORDS;
    logic [7:0]        REQ_TAG;
    logic [W-1:0]      BUSY_TAGS;
    logic [W*11-1:0]   SIZE_TAGS;
    logic [W-1:0]      COMPLETED_TAGS = '0;
    logic [63:0]       CURRENT_WINDOW_SIZE;
    logic [63:0]       WORD_COUNT;
    logic              BUSY;
    logic              DONE;

    dma_rq_tag_manager #(.C_WINDOW_SIZE(W), .C_LOG2_MAX_READ_REQUEST(N)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_DWORDS(REQ_DWORDS), .REQ_TAG(REQ_TAG),
        .BUSY_TAGS(BUSY_TAGS), .SIZE_TAGS(SIZE_TAGS), .COMPLETED_TAGS(COMPLETED_TAGS),
        .CURRENT_WINDOW_SIZE(CURRENT_WINDOW_SIZE), .WORD_COUNT(WORD_COUNT),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pending request list of the current command plus per-tag occupancy.
    typedef struct { logic [63:0] addr; int dw; } req_t;
    req_t         exp_q[$];
    logic [W-1:0] m_busy;
    int           m_size[W];
    logic [63:0]  m_wc;
    logic         m_active;
    logic         m_busy_flag;
    logic         m_done;
    logic         hold_prev;
    logic [63:0]  hold_addr;
    logic [10:0]  hold_dw;
    logic [7:0]   hold_tag;

    task automatic model_reset();
        exp_q.delete();
        m_busy      = '0;
        m_wc        = '0;
        m_active    = 1'b0;
        m_busy_flag = 1'b0;
        m_done      = 1'b0;
        hold_prev   = 1'b0;
        for (int j = 0; j < W; j++) m_size[j] = 0;
    endtask

    task automatic split_cmd(input logic [63:0] addr, input logic [31:0] len);
        logic [63:0] a;
        logic [63:0] rem;
        logic [63:0] room;
        logic [63:0] c;
        a   = addr & ~64'h3;
        rem = {32'h0, len & ~32'h3};
        while (rem != 0) begin
            room = 64'(MRRS) - (a % 64'(MRRS));
            c    = (rem < room) ? rem : room;
            exp_q.push_back('{addr: a, dw: int'(c / 4)});
            a   = a + c;
            rem = rem - c;
        end
    endtask

    always @(negedge CLK) begin : compare_proc
        logic [W-1:0] old_busy;
        logic         nd;
        logic         hs_now;
        if (!RST_N) begin
            model_reset();
        end else begin
            check_output("cmd_ready", CMD_READY, !m_active);
            check_output("busy", BUSY, m_busy_flag);
            check_output("done", DONE, m_done);
            check_output("busy_tags", BUSY_TAGS, m_busy);
            check_output("window_size", CURRENT_WINDOW_SIZE, $countones(m_busy));
            check_output("word_count", WORD_COUNT, m_wc);
            for (int j = 0; j < W; j++)
                check_output($sformatf("size_tag%0d", j), SIZE_TAGS[11*j +: 11], m_size[j]);
            if (exp_q.size() == 0) check_output("req_valid_no_work", REQ_VALID, 0);
            if (hold_prev) begin
                check_output("hold_valid", REQ_VALID, 1);
                check_output("hold_addr", REQ_ADDR, hold_addr);
                check_output("hold_dwords", REQ_DWORDS, hold_dw);
                check_output("hold_tag", REQ_TAG, hold_tag);
            end
            hold_prev = REQ_VALID && !REQ_READY;
            hold_addr = REQ_ADDR;
            hold_dw   = REQ_DWORDS;
            hold_tag  = REQ_TAG;

            old_busy = m_busy;
            nd       = 1'b0;
            hs_now   = REQ_VALID && REQ_READY;
            if (CMD_VALID && CMD_READY) begin
                exp_q.delete();
                split_cmd(CMD_ADDR, CMD_LEN);
                m_wc = '0;
                if (exp_q.size() == 0) nd = 1'b1;
                else begin
                    m_active    = 1'b1;
                    m_busy_flag = 1'b1;
                end
            end
            if (hs_now && exp_q.size() != 0) begin
                check_output("req_addr", REQ_ADDR, exp_q[0].addr);
                check_output("req_dwords", REQ_DWORDS, exp_q[0].dw);
                check_output("req_tag_free", (REQ_TAG < 8'(W)) ? old_busy[REQ_TAG[3:0]] : 1'b1, 0);
                m_busy[REQ_TAG[3:0]] = 1'b1;
                m_size[REQ_TAG[3:0]] = exp_q[0].dw;
                m_wc = m_wc + 64'(exp_q[0].dw);
                void'(exp_q.pop_front());
            end
            m_busy = m_busy & ~(COMPLETED_TAGS & old_busy);
            if (m_active && exp_q.size() == 0 && old_busy == '0 && !REQ_VALID) begin
                nd          = 1'b1;
                m_active    = 1'b0;
                m_busy_flag = 1'b0;
            end
            m_done = nd;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [63:0] addr, input logic [31:0] len);
        CMD_VALID = 1'b1;
        CMD_ADDR  = addr;
        CMD_LEN   = len;
        step();
        CMD_VALID = 1'b0;
    endtask

    task automatic pulse_complete(input logic [W-1:0] mask);
        COMPLETED_TAGS = mask;
        step();
        COMPLETED_TAGS = '0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check_output("done_seen", DONE, 1);
        step();
    endtask

    task automatic check_req(input string name, input logic [63:0] addr, input int dw, input int tag);
        check_output({name, "_valid"}, REQ_VALID, 1);
        check_output({name, "_addr"}, REQ_ADDR, addr);
        check_output({name, "_dwords"}, REQ_DWORDS, dw);
        check_output({name, "_tag"}, REQ_TAG, tag);
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, "_cmd_ready"}, CMD_READY, 1);
        check_output({name, "_req_valid"}, REQ_VALID, 0);
        check_output({name, "_req_addr"}, REQ_ADDR, 0);
        check_output({name, "_req_dwords"}, REQ_DWORDS, 0);
        check_output({name, "_req_tag"}, REQ_TAG, 0);
        check_output({name, "_busy_tags"}, BUSY_TAGS, 0);
        check_output({name, "_size_tags"}, |SIZE_TAGS, 0);
        check_output({name, "_window"}, CURRENT_WINDOW_SIZE, 0);
        check_output({name, "_word_count"}, WORD_COUNT, 0);
        check_output({name, "_busy"}, BUSY, 0);
        check_output({name, "_done"}, DONE, 0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check_reset_values("rst");
        step();

        // Aligned 1 KiB read: two full-MRRS requests back to back.
        REQ_READY = 1'b1;
        apply_stimulus(64'h1000, 32'd1024);
        check_req("t2_r0", 64'h1000, 128, 0);
        check_output("t2_busy", BUSY, 1);
        step();
        check_req("t2_r1", 64'h1200, 128, 1);
        step();
        check_output("t2_idle_valid", REQ_VALID, 0);
        check_output("t2_busy_tags", BUSY_TAGS, 16'h0003);
        check_output("t2_size0", SIZE_TAGS[10:0], 128);
        check_output("t2_size1", SIZE_TAGS[21:11], 128);
        check_output("t2_word_count", WORD_COUNT, 256);
        check_output("t2_window", CURRENT_WINDOW_SIZE, 2);
        pulse_complete(16'h0004);
        check_output("t2_stray_completion", BUSY_TAGS, 16'h0003);
        pulse_complete(16'h0003);
        check_output("t2_freed", BUSY_TAGS, 0);
        check_output("t2_done_early", DONE, 0);
        check_output("t2_busy_held", BUSY, 1);
        step();
        check_output("t2_done", DONE, 1);
        check_output("t2_busy_fall", BUSY, 0);
        step();
        check_output("t2_done_single", DONE, 0);
        check_output("t2_cmd_ready", CMD_READY, 1);

        // Unaligned start: first request stops at the 512-byte boundary.
        apply_stimulus(64'h1F0, 32'd64);
        check_req("t3_r0", 64'h1F0, 4, 0);
        step();
        check_req("t3_r1", 64'h200, 12, 1);
        step();
        check_output("t3_size0", SIZE_TAGS[10:0], 4);
        check_output("t3_size1", SIZE_TAGS[21:11], 12);
        check_output("t3_word_count", WORD_COUNT, 16);
        pulse_complete(16'h0003);
        wait_done(10);

        // Window exhaustion, then reuse of a single freed tag.
        apply_stimulus(64'h0, 32'd8704);
        for (int i = 0; i < W; i++) begin
            check_req($sformatf("t4_r%0d", i), 64'(i * 512), 128, i);
            step();
        end
        check_output("t4_full_valid", REQ_VALID, 0);
        check_output("t4_full_window", CURRENT_WINDOW_SIZE, 16);
        check_output("t4_full_tags", BUSY_TAGS, 16'hFFFF);
        repeat (3) step();
        check_output("t4_still_stalled", REQ_VALID, 0);
        pulse_complete(16'h0020);
        check_output("t4_tag5_freed", BUSY_TAGS, 16'hFFDF);
        check_output("t4_not_yet", REQ_VALID, 0);
        step();
        check_req("t4_r16", 64'h2000, 128, 5);
        step();
        check_output("t4_refull", BUSY_TAGS, 16'hFFFF);
        pulse_complete(16'hFFFF);
        wait_done(10);

        // Backpressure: payload must hold while REQ_READY is low.
        REQ_READY = 1'b0;
        apply_stimulus(64'h3000, 32'd1024);
        for (int i = 0; i < 5; i++) begin
            check_req($sformatf("t5_hold%0d", i), 64'h3000, 128, 0);
            check_output("t5_hold_tags", BUSY_TAGS, 0);
            step();
        end
        REQ_READY = 1'b1;
        step();
        check_req("t5_r1", 64'h3200, 128, 1);
        check_output("t5_tags", BUSY_TAGS, 16'h0001);
        step();
        check_output("t5_tags2", BUSY_TAGS, 16'h0003);
        pulse_complete(16'h0003);
        wait_done(10);

        // Zero-length command completes immediately without requests.
        apply_stimulus(64'h40, 32'd0);
        check_output("t6_done", DONE, 1);
        check_output("t6_no_req", REQ_VALID, 0);
        check_output("t6_cmd_ready", CMD_READY, 1);
        step();
        check_output("t6_done_single", DONE, 0);

        // Asynchronous reset in the middle of issuing.
        apply_stimulus(64'h5000, 32'd8192);
        step();
        step();
        check_output("t7_pre_tags", BUSY_TAGS, 16'h0003);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_values("t7_async");
        step();
        RST_N = 1'b1;
        step();
        pulse_complete(16'h0003);
        check_output("t7_stale_completion", BUSY_TAGS, 0);
        step();
        check_output("t7_no_done", DONE, 0);
        check_output("t7_ready", CMD_READY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
